// File: rtl/afifo_wr_arb_if.sv
// rtl/afifo_wr_arb_if.sv - requester handshake and memory write port of the async FIFO write side
interface afifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int PTR_WIDTH  = 5
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            grant_o;
    logic                          mem_wen_o;
    logic [PTR_WIDTH-1:0]          mem_waddr_o;
    logic [DATA_WIDTH-1:0]         mem_wdata_o;

    modport master (
        output req_valid_i, req_last_i, req_data_i,
        input  req_ready_o, grant_o, mem_wen_o, mem_waddr_o, mem_wdata_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_data_i,
        output req_ready_o, grant_o, mem_wen_o, mem_waddr_o, mem_wdata_o
    );
endinterface

// File: rtl/afifo_wr_arb.sv
// rtl/afifo_wr_arb.sv - async FIFO write side: round-robin packet arbiter, write pointer, full/fill status
module afifo_wr_arb #(
    parameter int PTR_WIDTH  = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int AFULL_TH   = 4
) (
    input  logic                 wr_clk_i,
    input  logic                 rstn_i,
    afifo_wr_arb_if.slave        bus,
    input  logic [PTR_WIDTH:0]   rp2wp_gray_i,
    output logic [PTR_WIDTH:0]   wptr_gray_o,
    output logic                 full_o,
    output logic                 afull_o,
    output logic [PTR_WIDTH:0]   fill_lvl_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_WIDTH:0] DEPTH_LVL = (PTR_WIDTH+1)'(2**PTR_WIDTH);
    localparam logic [PTR_WIDTH:0] AFULL_LVL = (PTR_WIDTH+1)'(2**PTR_WIDTH - AFULL_TH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     rr_last_q;
    logic [PTR_WIDTH:0]   wptr_bin_q;
    logic [PTR_WIDTH:0]   wptr_bin_inc;
    logic [PTR_WIDTH:0]   rp_bin;
    logic [NUM_REQ-1:0]   ready;
    logic                 accept;
    logic                 accept_last;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;

    // Gray-to-binary of the synchronised read pointer, then modular distance.
    always_comb begin
        rp_bin = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            rp_bin[i] = ^(rp2wp_gray_i >> i);
        end
    end

    assign fill_lvl_o   = wptr_bin_q - rp_bin;
    assign full_o       = (fill_lvl_o == DEPTH_LVL);
    assign afull_o      = (fill_lvl_o >= AFULL_LVL);
    assign wptr_bin_inc = wptr_bin_q + 1'b1;

    // First valid requester strictly after the last winner, wrapping.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_last_q) + k) % NUM_REQ);
            if (!pick_found && bus.req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge wr_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found)  state_d = BUSY;
            BUSY:    if (accept_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready       = '0;
        accept      = 1'b0;
        accept_last = 1'b0;
        if (state_q == BUSY) begin
            ready       = grant_q & {NUM_REQ{~full_o}};
            accept      = |(bus.req_valid_i & ready);
            accept_last = |(bus.req_valid_i & bus.req_last_i & ready);
        end
    end

    always_comb begin
        bus.mem_wdata_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                bus.mem_wdata_o = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.grant_o     = grant_q;
    assign bus.mem_wen_o   = accept;
    assign bus.mem_waddr_o = wptr_bin_q[PTR_WIDTH-1:0];

    always_ff @(posedge wr_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_last_q   <= IDX_W'(NUM_REQ-1);
            wptr_bin_q  <= '0;
            wptr_gray_o <= '0;
        end else begin
            if (state_q == IDLE && pick_found) begin
                grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                gidx_q  <= pick_idx;
            end
            if (accept_last) begin
                grant_q   <= '0;
                rr_last_q <= gidx_q;
            end
            // Gray is encoded from the incremented binary so it updates with a single bit flip.
            if (accept) begin
                wptr_bin_q  <= wptr_bin_inc;
                wptr_gray_o <= wptr_bin_inc ^ (wptr_bin_inc >> 1);
            end
        end
    end
endmodule

// File: tb/tb_afifo_wr_arb.sv
// tb/tb_afifo_wr_arb.sv - directed self-checking bench for afifo_wr_arb
module tb_afifo_wr_arb;
    localparam int PW = 5;
    localparam int DW = 64;
    localparam int NR = 4;

    logic          wr_clk_i = 1'b0;
    logic          rstn_i   = 1'b0;
    logic [PW:0]   rp2wp_gray_i;
    logic [PW:0]   wptr_gray_o;
    logic          full_o;
    logic          afull_o;
    logic [PW:0]   fill_lvl_o;

    int checks   = 0;
    int failures = 0;

    afifo_wr_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    afifo_wr_arb #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .NUM_REQ(NR), .AFULL_TH(4)) dut (
        .wr_clk_i     (wr_clk_i),
        .rstn_i       (rstn_i),
        .bus          (bus),
        .rp2wp_gray_i (rp2wp_gray_i),
        .wptr_gray_o  (wptr_gray_o),
        .full_o       (full_o),
        .afull_o      (afull_o),
        .fill_lvl_o   (fill_lvl_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW:0] to_gray(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        @(negedge wr_clk_i);
        rstn_i           = 1'b0;
        bus.req_valid_i  = '0;
        bus.req_last_i   = '0;
        bus.req_data_i   = '0;
        rp2wp_gray_i     = '0;
        repeat (2) @(negedge wr_clk_i);
        rstn_i = 1'b1;
    endtask

    // Drives one beat from requester r and returns just before the edge that accepts it.
    task automatic beat(input int r, input logic [63:0] d, input logic last);
        int cnt;
        @(negedge wr_clk_i);
        bus.req_valid_i             = '0;
        bus.req_last_i              = '0;
        bus.req_valid_i[r]          = 1'b1;
        bus.req_last_i[r]           = last;
        bus.req_data_i[r*DW +: DW]  = d;
        #1;
        cnt = 0;
        while (!bus.req_ready_o[r] && cnt < 50) begin
            @(negedge wr_clk_i);
            #1;
            cnt++;
        end
        if (cnt >= 50) chk("beat_timeout", 64'(cnt), 64'd0);
    endtask

    task automatic idle_inputs();
        @(negedge wr_clk_i);
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        #1;
    endtask

    initial begin
        logic [3:0] exp_grant [5];
        exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000; exp_grant[4] = 4'b0001;

        // Reset state
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_data_i  = '0;
        rp2wp_gray_i    = '0;
        #12;
        chk("rst_grant", 64'(bus.grant_o), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_wen", 64'(bus.mem_wen_o), 64'd0);
        chk("rst_waddr", 64'(bus.mem_waddr_o), 64'd0);
        chk("rst_wdata", bus.mem_wdata_o, 64'd0);
        chk("rst_gray", 64'(wptr_gray_o), 64'd0);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_afull", 64'(afull_o), 64'd0);
        chk("rst_fill", 64'(fill_lvl_o), 64'd0);
        @(negedge wr_clk_i);
        rstn_i = 1'b1;

        // Three-beat packet from requester 1
        @(negedge wr_clk_i);
        bus.req_valid_i = 4'b0010;
        bus.req_data_i[1*DW +: DW] = 64'hA0;
        #1;
        chk("t2_idle_grant", 64'(bus.grant_o), 64'd0);
        chk("t2_idle_wen", 64'(bus.mem_wen_o), 64'd0);
        @(negedge wr_clk_i); #1;
        chk("t2_grant", 64'(bus.grant_o), 64'b0010);
        chk("t2_ready", 64'(bus.req_ready_o), 64'b0010);
        chk("t2_wen0", 64'(bus.mem_wen_o), 64'd1);
        chk("t2_addr0", 64'(bus.mem_waddr_o), 64'd0);
        chk("t2_data0", bus.mem_wdata_o, 64'hA0);
        chk("t2_gray0", 64'(wptr_gray_o), 64'd0);
        @(negedge wr_clk_i);
        bus.req_data_i[1*DW +: DW] = 64'hA1;
        #1;
        chk("t2_addr1", 64'(bus.mem_waddr_o), 64'd1);
        chk("t2_data1", bus.mem_wdata_o, 64'hA1);
        chk("t2_gray1", 64'(wptr_gray_o), 64'd1);
        @(negedge wr_clk_i);
        bus.req_data_i[1*DW +: DW] = 64'hA2;
        bus.req_last_i = 4'b0010;
        #1;
        chk("t2_addr2", 64'(bus.mem_waddr_o), 64'd2);
        chk("t2_gray2", 64'(wptr_gray_o), 64'd3);
        idle_inputs();
        chk("t2_end_grant", 64'(bus.grant_o), 64'd0);
        chk("t2_end_gray", 64'(wptr_gray_o), 64'd2);
        chk("t2_end_fill", 64'(fill_lvl_o), 64'd3);
        chk("t2_end_wen", 64'(bus.mem_wen_o), 64'd0);

        // Round-robin with all four requesters sending 1-beat packets
        do_reset();
        @(negedge wr_clk_i);
        bus.req_valid_i = 4'b1111;
        bus.req_last_i  = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c % 2 == 1) begin
                chk($sformatf("t3_grant%0d", c), 64'(bus.grant_o), 64'(exp_grant[c/2]));
                chk($sformatf("t3_wen%0d", c), 64'(bus.mem_wen_o), 64'd1);
            end else begin
                chk($sformatf("t3_gap%0d", c), 64'(bus.grant_o), 64'd0);
            end
            @(negedge wr_clk_i);
        end
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        #1;
        chk("t3_fill", 64'(fill_lvl_o), 64'd5);

        // Fill to full, stall, then release by advancing the read pointer
        do_reset();
        for (int n = 0; n < 32; n++) begin
            beat(0, 64'(n), 1'b0);
            if (n == 27) chk("t4_afull_27", 64'(afull_o), 64'd0);
            if (n == 28) chk("t4_afull_28", 64'(afull_o), 64'd1);
        end
        @(negedge wr_clk_i); #1;
        chk("t4_full", 64'(full_o), 64'd1);
        chk("t4_fill32", 64'(fill_lvl_o), 64'd32);
        chk("t4_ready0", 64'(bus.req_ready_o), 64'd0);
        chk("t4_nowen", 64'(bus.mem_wen_o), 64'd0);
        repeat (3) @(negedge wr_clk_i);
        #1;
        chk("t4_stall_wen", 64'(bus.mem_wen_o), 64'd0);
        chk("t4_stall_grant", 64'(bus.grant_o), 64'b0001);
        rp2wp_gray_i = 6'b000110;
        #1;
        chk("t4_unfull", 64'(full_o), 64'd0);
        chk("t4_fill28", 64'(fill_lvl_o), 64'd28);
        chk("t4_afull", 64'(afull_o), 64'd1);
        chk("t4_ready", 64'(bus.req_ready_o), 64'b0001);
        chk("t4_wen", 64'(bus.mem_wen_o), 64'd1);
        chk("t4_addr", 64'(bus.mem_waddr_o), 64'd0);
        chk("t4_gray32", 64'(wptr_gray_o), 64'b110000);
        bus.req_last_i = 4'b0001;
        idle_inputs();
        chk("t4_fill29", 64'(fill_lvl_o), 64'd29);
        chk("t4_grant_end", 64'(bus.grant_o), 64'd0);

        // Pointer wrap with the read pointer trailing the writes
        do_reset();
        for (int n = 0; n < 70; n++) begin
            beat(3, 64'(n), n == 69);
            if (n == 31) chk("t5_addr31", 64'(bus.mem_waddr_o), 64'd31);
            if (n == 32) chk("t5_addr32", 64'(bus.mem_waddr_o), 64'd0);
            if (n == 63) begin
                chk("t5_addr63", 64'(bus.mem_waddr_o), 64'd31);
                chk("t5_gray63", 64'(wptr_gray_o), 64'b100000);
            end
            if (n == 64) begin
                chk("t5_addr64", 64'(bus.mem_waddr_o), 64'd0);
                chk("t5_gray64", 64'(wptr_gray_o), 64'd0);
                chk("t5_data64", bus.mem_wdata_o, 64'd64);
            end
            @(posedge wr_clk_i);
            #1;
            rp2wp_gray_i = to_gray(6'((n + 1) % 64));
        end
        idle_inputs();
        chk("t5_fill", 64'(fill_lvl_o), 64'd0);
        chk("t5_gray70", 64'(wptr_gray_o), 64'(to_gray(6'd6)));

        // Asynchronous reset in the middle of a packet
        do_reset();
        beat(2, 64'h55, 1'b0);
        @(negedge wr_clk_i);
        bus.req_data_i[2*DW +: DW] = 64'h66;
        #1;
        chk("t6_pre_gray", 64'(wptr_gray_o), 64'd1);
        chk("t6_pre_grant", 64'(bus.grant_o), 64'b0100);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_grant", 64'(bus.grant_o), 64'd0);
        chk("t6_rst_ready", 64'(bus.req_ready_o), 64'd0);
        chk("t6_rst_wen", 64'(bus.mem_wen_o), 64'd0);
        chk("t6_rst_gray", 64'(wptr_gray_o), 64'd0);
        chk("t6_rst_addr", 64'(bus.mem_waddr_o), 64'd0);
        chk("t6_rst_fill", 64'(fill_lvl_o), 64'd0);
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        @(negedge wr_clk_i);
        rstn_i = 1'b1;
        bus.req_valid_i = 4'b0101;
        bus.req_last_i  = 4'b0101;
        #1;
        chk("t6_idle_grant", 64'(bus.grant_o), 64'd0);
        @(negedge wr_clk_i); #1;
        chk("t6_first_grant", 64'(bus.grant_o), 64'b0001);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
